// File: rtl/router_recv_ack.sv
// ---------------------------------------------------------------------------
// router_recv_ack
//
// Receive-and-acknowledge endpoint for a router link. A request packet
// addressed to this endpoint (LOCAL_ADDR / LOCAL_DFX) is held for the host.
// Once the host signals it has consumed the packet, an acknowledge is sent
// back to the original source. Packets addressed elsewhere are consumed and
// discarded.
//
// Parameters:
//   LOCAL_ADDR      10-bit router address this endpoint answers to
//   LOCAL_DFX       2-bit DFX region this endpoint answers to
//
// Optional feature (compile-time macro RECV_DROP_CNT_EN):
//   When defined, port drop_cnt exists and counts misrouted packets,
//   saturating at 8'hFF. When undefined, the port and register are absent.
//
// Ports:
//   clk              in   clock, all state updates on rising edge
//   rst              in   asynchronous active-high reset
//   in_valid         in   request packet valid from the link
//   in_ready         out  endpoint can accept a request (state IDLE)
//   in_src_addr      in   requester address
//   in_dst_addr      in   target address
//   in_src_dfx       in   requester DFX region
//   in_dst_dfx       in   target DFX region
//   valid_v_recv     out  a received packet is held for the host (state HOLD)
//   recv_src_addr    out  held packet source address
//   recv_src_dfx     out  held packet source DFX
//   check_recv_done  in   host has consumed the held packet
//   ack_valid        out  acknowledge valid toward the link (state ACK)
//   ack_ready        in   link accepts the acknowledge
//   ack_dst_addr     out  acknowledge target address
//   drop_cnt         out  misrouted packet count (RECV_DROP_CNT_EN only)
//   ack_dst_dfx      out  acknowledge target DFX
//
// All outputs are registers or decodes of the state register; no input
// reaches an output combinationally.
// ---------------------------------------------------------------------------
module router_recv_ack #(
    parameter logic [9:0] LOCAL_ADDR = 10'h005,
    parameter logic [1:0] LOCAL_DFX  = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_src_addr,
    input  logic [9:0] in_dst_addr,
    input  logic [1:0] in_src_dfx,
    input  logic [1:0] in_dst_dfx,
    output logic       valid_v_recv,
    output logic [9:0] recv_src_addr,
    output logic [1:0] recv_src_dfx,
    input  logic       check_recv_done,
    output logic       ack_valid,
    input  logic       ack_ready,
    output logic [9:0] ack_dst_addr,
`ifdef RECV_DROP_CNT_EN
    output logic [7:0] drop_cnt,
`endif
    output logic [1:0] ack_dst_dfx
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        ACK  = 2'b10
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic       w_accept;
    logic       w_match;
    logic       w_latch;

    logic [9:0] r_recv_src_addr;
    logic [1:0] r_recv_src_dfx;
    logic [9:0] r_ack_dst_addr;
    logic [1:0] r_ack_dst_dfx;

    // A transfer happens only in IDLE, since in_ready is the IDLE decode.
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_match  = (in_dst_addr == LOCAL_ADDR) && (in_dst_dfx == LOCAL_DFX);
    assign w_latch  = w_accept && w_match;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                // Mismatched transfers are swallowed without leaving IDLE.
                if (w_latch) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                // No timeout: the host may take arbitrarily long.
                if (check_recv_done) begin
                    w_state_next = ACK;
                end
            end
            ACK: begin
                if (ack_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packet fields. Loaded only on a matching transfer, so they stay
    // stable through HOLD and ACK and keep their value afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_recv_src_addr <= 10'h000;
            r_recv_src_dfx  <= 2'b00;
            r_ack_dst_addr  <= 10'h000;
            r_ack_dst_dfx   <= 2'b00;
        end else if (w_latch) begin
            r_recv_src_addr <= in_src_addr;
            r_recv_src_dfx  <= in_src_dfx;
            r_ack_dst_addr  <= in_src_addr;
            r_ack_dst_dfx   <= in_src_dfx;
        end
    end

`ifdef RECV_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Misrouted packet counter, saturating.
    // ------------------------------------------------------------------
    logic       w_drop;
    logic [7:0] r_drop_cnt;

    assign w_drop = w_accept && !w_match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    // ------------------------------------------------------------------
    // Outputs: state decodes and registered fields only.
    // ------------------------------------------------------------------
    assign in_ready      = (r_state == IDLE);
    assign valid_v_recv  = (r_state == HOLD);
    assign ack_valid     = (r_state == ACK);
    assign recv_src_addr = r_recv_src_addr;
    assign recv_src_dfx  = r_recv_src_dfx;
    assign ack_dst_addr  = r_ack_dst_addr;
    assign ack_dst_dfx   = r_ack_dst_dfx;

endmodule

// File: tb/tb_router_recv_ack.sv
// ---------------------------------------------------------------------------
// tb_router_recv_ack
//
// Self-checking bench for router_recv_ack. Directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model
// built from packet queues: a packet waiting for the host, then a packet
// waiting for its acknowledge. The endpoint is ready when both are empty.
// drop_cnt is checked only when RECV_DROP_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_router_recv_ack;

    localparam logic [9:0] LADDR = 10'h005;
    localparam logic [1:0] LDFX  = 2'b10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_src_addr = '0;
    logic [9:0] in_dst_addr = '0;
    logic [1:0] in_src_dfx = '0;
    logic [1:0] in_dst_dfx = '0;
    logic       valid_v_recv;
    logic [9:0] recv_src_addr;
    logic [1:0] recv_src_dfx;
    logic       check_recv_done = 1'b0;
    logic       ack_valid;
    logic       ack_ready = 1'b0;
    logic [9:0] ack_dst_addr;
    logic [1:0] ack_dst_dfx;
`ifdef RECV_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    router_recv_ack #(
        .LOCAL_ADDR (LADDR),
        .LOCAL_DFX  (LDFX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_src_addr     (in_src_addr),
        .in_dst_addr     (in_dst_addr),
        .in_src_dfx      (in_src_dfx),
        .in_dst_dfx      (in_dst_dfx),
        .valid_v_recv    (valid_v_recv),
        .recv_src_addr   (recv_src_addr),
        .recv_src_dfx    (recv_src_dfx),
        .check_recv_done (check_recv_done),
        .ack_valid       (ack_valid),
        .ack_ready       (ack_ready),
        .ack_dst_addr    (ack_dst_addr),
`ifdef RECV_DROP_CNT_EN
        .drop_cnt        (drop_cnt),
`endif
        .ack_dst_dfx     (ack_dst_dfx)
    );

    always #5 clk = ~clk;

    // Behavioural model
    typedef struct packed {
        logic [9:0] addr;
        logic [1:0] dfx;
    } pkt_t;

    pkt_t held_q[$];     // delivered to host, not yet consumed
    pkt_t ackq[$];       // consumed, acknowledge not yet accepted
    pkt_t m_last;        // last matching packet
    int   m_drop;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        held_q.delete();
        ackq.delete();
        m_last = '0;
        m_drop = 0;
    endtask

    // Apply the effect of the upcoming rising edge given the current inputs.
    task automatic model_edge();
        pkt_t p;
        if (held_q.size() == 0 && ackq.size() == 0) begin
            if (in_valid) begin
                if (in_dst_addr == LADDR && in_dst_dfx == LDFX) begin
                    p.addr = in_src_addr;
                    p.dfx  = in_src_dfx;
                    held_q.push_back(p);
                    m_last = p;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end else if (held_q.size() != 0) begin
            if (check_recv_done) ackq.push_back(held_q.pop_front());
        end else begin
            if (ack_ready) void'(ackq.pop_front());
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(held_q.size() == 0 && ackq.size() == 0));
        chk("valid_v_recv", 32'(valid_v_recv), 32'(held_q.size() != 0));
        chk("ack_valid", 32'(ack_valid), 32'(ackq.size() != 0));
        chk("recv_src_addr", 32'(recv_src_addr), 32'(m_last.addr));
        chk("recv_src_dfx", 32'(recv_src_dfx), 32'(m_last.dfx));
        chk("ack_dst_addr", 32'(ack_dst_addr), 32'(m_last.addr));
        chk("ack_dst_dfx", 32'(ack_dst_dfx), 32'(m_last.dfx));
`ifdef RECV_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // One clock: model the edge, let it happen, check just after.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [9:0] sa, input logic [1:0] sd,
                         input logic [9:0] da, input logic [1:0] dd,
                         input logic done, input logic ar);
        in_valid        = v;
        in_src_addr     = sa;
        in_src_dfx      = sd;
        in_dst_addr     = da;
        in_dst_dfx      = dd;
        check_recv_done = done;
        ack_ready       = ar;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 10'h0, 2'b00, 10'h0, 2'b00, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse, checked before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset values
        do_reset();
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Basic round trip; transfer on the first edge after reset release
        drive(1'b1, 10'h001, 2'b01, LADDR, LDFX, 1'b0, 1'b1);
        cycle();
        chk("rt_valid_v_recv", 32'(valid_v_recv), 32'd1);
        chk("rt_recv_src_addr", 32'(recv_src_addr), 32'h001);
        drive(1'b0, 10'h0, 2'b00, 10'h0, 2'b00, 1'b1, 1'b1);
        cycle();
        chk("rt_ack_valid", 32'(ack_valid), 32'd1);
        chk("rt_ack_dst_addr", 32'(ack_dst_addr), 32'h001);
        chk("rt_ack_dst_dfx", 32'(ack_dst_dfx), 32'h1);
        drive(1'b0, 10'h0, 2'b00, 10'h0, 2'b00, 1'b0, 1'b1);
        cycle();
        chk("rt_in_ready", 32'(in_ready), 32'd1);
        chk("rt_ack_done", 32'(ack_valid), 32'd0);

        // Misrouted packet
        drive(1'b1, 10'h033, 2'b11, 10'h007, 2'b11, 1'b1, 1'b1);
        cycle();
        idle_inputs();
        cycle();
        chk("mis_in_ready", 32'(in_ready), 32'd1);
`ifdef RECV_DROP_CNT_EN
        chk("mis_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // Long hold; a second request must not be accepted
        drive(1'b1, 10'h2AB, 2'b10, LADDR, LDFX, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 10'h111, 2'b00, LADDR, LDFX, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) cycle();
        chk("hold_valid", 32'(valid_v_recv), 32'd1);
        chk("hold_src", 32'(recv_src_addr), 32'h2AB);

        // Ack back-pressure for 20 cycles
        drive(1'b0, 10'h0, 2'b00, 10'h0, 2'b00, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 10'h0, 2'b00, 10'h0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) cycle();
        chk("bp_ack_valid", 32'(ack_valid), 32'd1);
        chk("bp_ack_addr", 32'(ack_dst_addr), 32'h2AB);
        drive(1'b0, 10'h0, 2'b00, 10'h0, 2'b00, 1'b0, 1'b1);
        cycle();
        chk("bp_idle", 32'(in_ready), 32'd1);

        // Reset during HOLD abandons the packet
        drive(1'b1, 10'h155, 2'b11, LADDR, LDFX, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 10'h0, 2'b00, 10'h0, 2'b00, 1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        chk("rst_no_ack", 32'(ack_valid), 32'd0);

        // 300 misrouted packets, varying which field mismatches
        for (int i = 0; i < 300; i++) begin
            logic [9:0] da;
            logic [1:0] dd;
            da = LADDR;
            dd = LDFX;
            if (i % 3 != 1) da = LADDR ^ 10'($urandom_range(1, 1023));
            if (i % 3 != 0) dd = LDFX ^ 2'($urandom_range(1, 3));
            drive(1'b1, 10'($urandom), 2'($urandom), da, dd, 1'($urandom), 1'($urandom));
            cycle();
        end
`ifdef RECV_DROP_CNT_EN
        chk("drop_sat", 32'(drop_cnt), 32'hFF);
`endif
        chk("drop_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic [9:0] da;
            logic [1:0] dd;
            if ($urandom_range(0, 1) == 0) begin
                da = LADDR;
                dd = LDFX;
            end else begin
                da = 10'($urandom);
                dd = 2'($urandom);
            end
            drive(1'($urandom_range(0, 1)), 10'($urandom), 2'($urandom), da, dd,
                  1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
